// File: rtl/thresh_ctrl_pkg.sv
// Shared constants for the threshold controller: config addresses, FSM codes, reset threshold.
package thr_pkg;

  localparam int         CFG_ADDR_W     = 2;
  localparam logic [1:0] CFG_THR_MANUAL = 2'd0;
  localparam logic [1:0] CFG_MODE       = 2'd1;
  localparam logic [1:0] CFG_OFFSET     = 2'd2;
  localparam logic [1:0] CFG_RSVD       = 2'd3;

  localparam logic [7:0] THRESH_RST_DEF = 8'h80;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FRAME = ST_FRAME,
    CALC  = ST_CALC
  } thr_state_e;

endpackage

// File: rtl/thresh_ctrl_if.sv
// Configuration write channel (valid/ready) of the threshold controller.
interface thresh_ctrl_if;
  import thr_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [7:0]            cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);

endinterface

// File: rtl/thresh_ctrl_accum.sv
// Per-frame luminance sum and pixel count; flags a frame that delivers more than 2^PIX_LOG2 pixels.
module thr_accum #(
  parameter int PIX_LOG2 = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [7:0]          i_gray,
  output logic [7+PIX_LOG2:0] o_sum,
  output logic                o_ovf
);

  localparam logic [PIX_LOG2:0] FULL = {1'b1, {PIX_LOG2{1'b0}}};

  logic [PIX_LOG2:0]   r_cnt;
  logic [7+PIX_LOG2:0] r_sum;
  logic                r_ovf;

  // Once the count is full, further pixels are dropped so the mean stays meaningful.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == FULL) begin
        r_ovf <= 1'b1;
      end else begin
        r_sum <= r_sum + {{PIX_LOG2{1'b0}}, i_gray};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sum = r_sum;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/thresh_ctrl.sv
// Frame-synchronous threshold controller: manual threshold, or (with THRESH_CTRL_AUTO_EN defined)
// auto threshold = clamp(frame mean + signed offset). Config writes are shadowed until frame_start.
module thresh_ctrl
  import thr_pkg::*;
#(
  parameter logic [7:0] THRESH_RST     = THRESH_RST_DEF,
  parameter int         FRAME_PIX_LOG2 = 16
) (
  input  logic         clk,
  input  logic         reset,
  thresh_ctrl_if.slave cfg,
  input  logic         frame_start,
  input  logic         frame_end,
  input  logic         pix_valid,
  input  logic [7:0]   gray,
  output logic [7:0]   thresh,
  output logic         auto_active,
  output logic         err
);

  thr_state_e r_state;
  thr_state_e w_end_state;
  logic [7:0] r_thr_pend;
  logic [7:0] r_thr_act;
  logic [7:0] r_thresh;
  logic       r_err;
  logic       w_wr;
  logic       w_fs;
  logic       w_restart;
  logic       w_auto_pend;
  logic       w_auto_act;
  logic       w_calc_upd;
  logic       w_ovf;
  logic [7:0] w_calc_thr;

  assign w_wr      = cfg.cfg_valid && cfg.cfg_ready;
  assign w_fs      = frame_start && (r_state != CALC);
  assign w_restart = frame_start && (r_state == FRAME);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_thr_pend <= THRESH_RST;
      r_thr_act  <= THRESH_RST;
    end else begin
      if (w_wr && (cfg.cfg_addr == CFG_THR_MANUAL)) r_thr_pend <= cfg.cfg_wdata;
      if (w_fs) r_thr_act <= r_thr_pend;
    end
  end

`ifdef THRESH_CTRL_AUTO_EN
  logic                      r_mode_pend;
  logic                      r_mode_act;
  logic [7:0]                r_off_pend;
  logic [7:0]                r_off_act;
  logic [7+FRAME_PIX_LOG2:0] w_sum;
  logic [7:0]                w_mean;
  logic signed [9:0]         w_adj;

  function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
    if (v < 10'sd0)        return 8'h00;
    else if (v > 10'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_pend <= 1'b0;
      r_mode_act  <= 1'b0;
      r_off_pend  <= 8'h00;
      r_off_act   <= 8'h00;
    end else begin
      if (w_wr && (cfg.cfg_addr == CFG_MODE))   r_mode_pend <= cfg.cfg_wdata[0];
      if (w_wr && (cfg.cfg_addr == CFG_OFFSET)) r_off_pend  <= cfg.cfg_wdata;
      if (w_fs) begin
        r_mode_act <= r_mode_pend;
        r_off_act  <= r_off_pend;
      end
    end
  end

  thr_accum #(.PIX_LOG2(FRAME_PIX_LOG2)) u_accum (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_fs),
    .i_en   (pix_valid && (r_state == FRAME)),
    .i_gray (gray),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_mean      = w_sum[FRAME_PIX_LOG2 +: 8];
  assign w_adj       = $signed({2'b00, w_mean}) + $signed({{2{r_off_act[7]}}, r_off_act});
  assign w_calc_thr  = sat_u8(w_adj);
  assign w_auto_pend = r_mode_pend;
  assign w_auto_act  = r_mode_act;
  assign w_calc_upd  = (r_state == CALC) && r_mode_act && !w_ovf;
  assign w_end_state = CALC;
  assign cfg.cfg_ready = (r_state != CALC);
`else
  logic w_unused_pix;
  assign w_unused_pix  = ^{pix_valid, gray, (FRAME_PIX_LOG2 != 0)};
  assign w_auto_pend   = 1'b0;
  assign w_auto_act    = 1'b0;
  assign w_calc_upd    = 1'b0;
  assign w_ovf         = 1'b0;
  assign w_calc_thr    = 8'h00;
  assign w_end_state   = IDLE;
  assign cfg.cfg_ready = 1'b1;
`endif

  // A frame_start while already in FRAME means frame_end went missing: restart the frame and flag it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      if (w_restart || w_ovf) r_err <= 1'b1;
      case (r_state)
        IDLE:    if (frame_start) r_state <= FRAME;
        FRAME:   if (!frame_start && frame_end) r_state <= w_end_state;
        CALC:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // In manual mode thresh tracks the active register; switching to auto holds it until the first CALC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_thresh <= THRESH_RST;
    else if (w_fs && !w_auto_pend)    r_thresh <= r_thr_pend;
    else if (!w_auto_act)             r_thresh <= r_thr_act;
    else if (w_calc_upd)              r_thresh <= w_calc_thr;
  end

  assign thresh      = r_thresh;
  assign auto_active = w_auto_act;
  assign err         = r_err;

endmodule

// File: tb/tb_thresh_ctrl.sv
// Scoreboard bench for thresh_ctrl: stimulus queues expected values per cycle, a negedge monitor checks them.
module tb_thresh_ctrl;
  import thr_pkg::*;

  localparam int K_THR  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RDY  = 2;
  localparam int K_AUTO = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] gray = 8'h00;
  logic [7:0] thresh;
  logic       auto_active;
  logic       err;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  thresh_ctrl_if cfg_bus();

  thresh_ctrl #(.THRESH_RST(8'h80), .FRAME_PIX_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (cfg_bus),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pix_valid   (pix_valid),
    .gray        (gray),
    .thresh      (thresh),
    .auto_active (auto_active),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_THR:   return thresh;
      K_ERR:   return {7'd0, err};
      K_RDY:   return {7'd0, cfg_bus.cfg_ready};
      default: return {7'd0, auto_active};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (actual(e.kind) !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", e.name, actual(e.kind), e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int dly, input int kind, input logic [7:0] v, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = data;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] thr, input string name);
    frame_start = 1'b1;
    exp_at(1, K_THR, thr, name);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    tick();
  endtask

  task automatic pixels(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      gray      = v;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic end_frame_calc(input logic [7:0] prev, input logic [7:0] thr, input string name);
    frame_end = 1'b1;
    exp_at(0, K_RDY, 8'h01, {name, "_rdy_pre"});
    exp_at(1, K_RDY, 8'h00, {name, "_rdy_calc"});
    exp_at(1, K_THR, prev,  {name, "_thr_hold"});
    exp_at(2, K_RDY, 8'h01, {name, "_rdy_post"});
    exp_at(2, K_THR, thr,   name);
    tick();
    frame_end = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_addr  = 2'd0;
    cfg_bus.cfg_wdata = 8'h00;
    do_reset();
    exp_at(0, K_THR,  8'h80, "rst_thresh");
    exp_at(0, K_ERR,  8'h00, "rst_err");
    exp_at(0, K_RDY,  8'h01, "rst_ready");
    exp_at(0, K_AUTO, 8'h00, "rst_auto");

    // manual threshold shadowed until frame_start
    cfg_write(CFG_THR_MANUAL, 8'h40);
    exp_at(0, K_THR, 8'h80, "man_before_fs");
    start_frame(8'h40, "man_after_fs");
    end_frame();

    // write coincident with frame_start waits one frame
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = CFG_THR_MANUAL;
    cfg_bus.cfg_wdata = 8'h30;
    frame_start       = 1'b1;
    exp_at(1, K_THR, 8'h40, "wr_same_fs");
    tick();
    cfg_bus.cfg_valid = 1'b0;
    frame_start       = 1'b0;
    exp_at(0, K_THR, 8'h40, "wr_same_hold");
    end_frame();
    cfg_write(CFG_RSVD, 8'h11);
    start_frame(8'h30, "wr_next_fs");
    end_frame();

    // missing frame_end
    start_frame(8'h30, "dbl_first");
    exp_at(0, K_ERR, 8'h00, "dbl_err_pre");
    frame_start = 1'b1;
    exp_at(1, K_ERR, 8'h01, "dbl_err");
    exp_at(1, K_THR, 8'h30, "dbl_thresh");
    tick();
    frame_start = 1'b0;
    end_frame();
    exp_at(0, K_ERR, 8'h01, "err_sticky");

    // reset mid-frame
    cfg_write(CFG_THR_MANUAL, 8'h55);
    start_frame(8'h55, "pre_rst_load");
    pixels(8, 8'h77);
    reset = 1'b1;
    exp_at(0, K_THR, 8'h80, "midrst_thr");
    exp_at(0, K_ERR, 8'h00, "midrst_err");
    tick();
    tick();
    reset = 1'b0;
    frame_start = 1'b1;
    exp_at(1, K_ERR, 8'h00, "post_rst_idle");
    exp_at(1, K_THR, 8'h80, "post_rst_thr");
    tick();
    frame_start = 1'b0;
    end_frame();

    // frame_end alone in IDLE is ignored; start+end together counts as start
    frame_end = 1'b1;
    exp_at(1, K_RDY, 8'h01, "fe_idle_ignored");
    tick();
    frame_end = 1'b0;
    tick();
    frame_start = 1'b1;
    frame_end   = 1'b1;
    exp_at(1, K_ERR, 8'h00, "fs_fe_no_err");
    tick();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    frame_start = 1'b1;
    exp_at(1, K_ERR, 8'h01, "fs_fe_is_start");
    tick();
    frame_start = 1'b0;
    end_frame();

`ifdef THRESH_CTRL_AUTO_EN
    do_reset();
    exp_at(0, K_ERR, 8'h00, "auto_rst_err");
    cfg_write(CFG_MODE, 8'h01);
    cfg_write(CFG_OFFSET, 8'hF0);
    exp_at(1, K_AUTO, 8'h01, "auto_active");
    start_frame(8'h80, "man2auto_hold");
    pixels(16, 8'h60);
    end_frame_calc(8'h80, 8'h50, "auto_mean");

    cfg_write(CFG_OFFSET, 8'h20);
    start_frame(8'h50, "auto_hi_start");
    pixels(16, 8'hFF);
    end_frame_calc(8'h50, 8'hFF, "auto_clamp_hi");

    cfg_write(CFG_OFFSET, 8'hF0);
    start_frame(8'hFF, "auto_lo_start");
    pixels(16, 8'h08);
    end_frame_calc(8'hFF, 8'h00, "auto_clamp_lo");

    cfg_write(CFG_OFFSET, 8'h00);
    exp_at(0, K_ERR, 8'h00, "ovf_err_pre");
    start_frame(8'h00, "ovf_start");
    pixels(17, 8'h10);
    exp_at(2, K_ERR, 8'h01, "ovf_err");
    end_frame_calc(8'h00, 8'h00, "ovf_thr_hold");

    cfg_write(CFG_MODE, 8'h00);
    cfg_write(CFG_THR_MANUAL, 8'h44);
    exp_at(1, K_AUTO, 8'h00, "auto2man_flag");
    start_frame(8'h44, "auto2man_load");
    end_frame();

    do_reset();
    cfg_write(CFG_MODE, 8'h01);
    start_frame(8'h80, "rst_auto_start");
    pixels(8, 8'h20);
    reset = 1'b1;
    exp_at(0, K_THR, 8'h80, "auto_midrst_thr");
    tick();
    tick();
    reset = 1'b0;
    cfg_write(CFG_MODE, 8'h01);
    start_frame(8'h80, "post_rst_auto_start");
    pixels(16, 8'h20);
    end_frame_calc(8'h80, 8'h20, "post_rst_auto_mean");
`endif

    tick();
    tick();
    tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
